// File: rtl/hist_eq_pkg.sv
// Shared constants and FSM state type for the histogram-equalisation LUT generator.
package hist_eq_pkg;

  localparam logic [15:0] CDF_BASE       = 16'd64;
  localparam logic [15:0] CDF_TOTAL_ADDR = 16'd127;
  localparam logic [15:0] CDF_MIN_ADDR   = 16'd128;
  localparam logic [15:0] LUT_BASE       = 16'd200;
  localparam int          LUT_WORDS      = 16;

  localparam int BIN_W = 32;
  localparam int LUT_W = 8;
  localparam int NUM_W = 40;

  typedef enum logic [3:0] {
    IDLE,
    RD_MIN,
    LD_MIN,
    RD_TOT,
    LD_TOT,
    RD_CDF,
    LD_CDF,
    DIV,
    WR,
    FIN
  } state_t;

endpackage

// File: rtl/lut_div8.sv
// Restoring divider producing an 8-bit quotient, one bit per cycle MSB first.
// The load cycle already computes bit 7, so the full quotient is presented on quot_o with valid_o in the 8th cycle.
module lut_div8
  import hist_eq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [BIN_W-1:0] den_i,
  output logic [LUT_W-1:0] quot_o,
  output logic             valid_o
);

  logic [NUM_W-1:0] rem_q, rem_d, remCur, trial;
  logic [BIN_W-1:0] den_q, denCur;
  logic [LUT_W-1:0] quot_q, quotCur;
  logic [2:0]       k_q, kCur;
  logic             run_q, active, qBit;

  always_comb begin
    active  = load_i | run_q;
    remCur  = load_i ? num_i : rem_q;
    denCur  = load_i ? den_i : den_q;
    kCur    = load_i ? 3'd7 : k_q;
    quotCur = load_i ? '0 : quot_q;
    trial   = NUM_W'(denCur) << kCur;
    qBit    = remCur >= trial;
    rem_d   = qBit ? (remCur - trial) : remCur;
    quot_o  = {quotCur[LUT_W-2:0], qBit};
    valid_o = active && (kCur == 3'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      k_q    <= '0;
      run_q  <= 1'b0;
    end else if (active) begin
      rem_q  <= rem_d;
      den_q  <= denCur;
      quot_q <= quot_o;
      k_q    <= kCur - 3'd1;
      run_q  <= (kCur != 3'd0);
    end else begin
      run_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/hist_eq_lut.sv
// Builds the 256-entry equalisation LUT from the CDF in scratch memory and writes it back as 16 packed words.
// Every bin spends 8 divider cycles even when den is zero, so a run always takes the same number of cycles.
module hist_eq_lut
  import hist_eq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [15:0]  ReadAddress1,
  input  logic [127:0] ReadBus1,
  output logic         WE,
  output logic [15:0]  WriteAddress,
  output logic [127:0] WriteBus,
  output logic         busy,
  output logic         done
);

  state_t           state_q;
  logic [5:0]       wordIdx_q;
  logic [4:0]       divCnt_q;
  logic [BIN_W-1:0] cdfMin_q, den_q;
  logic [127:0]     cdfWord_q, packed_q, packed_d;

  logic [BIN_W-1:0] binCdf, binDiff;
  logic [NUM_W-1:0] numer;
  logic [LUT_W-1:0] divQuot, lutByte;
  logic [3:0]       bytePos;
  logic [15:0]      nextCdfAddr;
  logic             divLoad, divValid, lastWord;

  // Bin selection, numerator clamp and the den == 0 override feeding the byte packer.
  always_comb begin
    binCdf      = cdfWord_q[BIN_W*divCnt_q[4:3] +: BIN_W];
    binDiff     = binCdf - cdfMin_q;
    numer       = (binCdf >= cdfMin_q) ? (NUM_W'(binDiff) * NUM_W'(255)) : '0;
    divLoad     = (state_q == DIV) && (divCnt_q[2:0] == 3'd0);
    lutByte     = (den_q == '0) ? ((binCdf >= cdfMin_q) ? 8'hFF : 8'h00) : divQuot;
    bytePos     = {wordIdx_q[1:0], divCnt_q[4:3]};
    lastWord    = (wordIdx_q[5:2] == 4'(LUT_WORDS-1));
    nextCdfAddr = CDF_BASE + 16'(wordIdx_q) + 16'd1;
    packed_d    = packed_q;
    if (divValid) packed_d[LUT_W*bytePos +: LUT_W] = lutByte;
  end

  lut_div8 u_div (
    .clk     (clk),
    .reset   (reset),
    .load_i  (divLoad),
    .num_i   (numer),
    .den_i   (den_q),
    .quot_o  (divQuot),
    .valid_o (divValid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wordIdx_q    <= '0;
      divCnt_q     <= '0;
      cdfMin_q     <= '0;
      den_q        <= '0;
      cdfWord_q    <= '0;
      packed_q     <= '0;
      ReadAddress1 <= '0;
      WE           <= 1'b0;
      WriteAddress <= '0;
      WriteBus     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      packed_q <= packed_d;
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            wordIdx_q    <= '0;
            divCnt_q     <= '0;
            ReadAddress1 <= CDF_MIN_ADDR;
            busy         <= 1'b1;
            state_q      <= RD_MIN;
          end
        end
        RD_MIN: state_q <= LD_MIN;
        LD_MIN: begin
          cdfMin_q     <= ReadBus1[BIN_W-1:0];
          ReadAddress1 <= CDF_TOTAL_ADDR;
          state_q      <= RD_TOT;
        end
        RD_TOT: state_q <= LD_TOT;
        LD_TOT: begin
          den_q        <= ReadBus1[127 -: BIN_W] - cdfMin_q;
          ReadAddress1 <= CDF_BASE;
          state_q      <= RD_CDF;
        end
        RD_CDF: state_q <= LD_CDF;
        LD_CDF: begin
          cdfWord_q <= ReadBus1;
          divCnt_q  <= '0;
          state_q   <= DIV;
        end
        DIV: begin
          divCnt_q <= divCnt_q + 5'd1;
          if (divCnt_q == 5'd31) begin
            // Four input words fill one output word; the last byte comes straight from packed_d.
            if (wordIdx_q[1:0] == 2'd3) begin
              WE           <= 1'b1;
              WriteAddress <= LUT_BASE + 16'(wordIdx_q[5:2]);
              WriteBus     <= packed_d;
              state_q      <= WR;
            end else begin
              wordIdx_q    <= wordIdx_q + 6'd1;
              ReadAddress1 <= nextCdfAddr;
              state_q      <= RD_CDF;
            end
          end
        end
        WR: begin
          WE <= 1'b0;
          if (lastWord) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= FIN;
          end else begin
            wordIdx_q    <= wordIdx_q + 6'd1;
            ReadAddress1 <= nextCdfAddr;
            state_q      <= RD_CDF;
          end
        end
        FIN: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_eq_lut.sv
// Directed bench for hist_eq_lut: uniform, single-bin and two-bin CDFs, ignored restart, and abort by reset.
module tb_hist_eq_lut;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [15:0]  ReadAddress1, WriteAddress;
  logic [127:0] ReadBus1, WriteBus;
  logic         WE, busy, done;

  logic [127:0] mem [0:255];

  int checkCount = 0;
  int errorCount = 0;
  int runLen, doneCnt, busyAtDone, weCnt, orderErr;

  localparam logic [127:0] GARBAGE = {4{32'hDEADBEEF}};

  always #5 clk = ~clk;

  hist_eq_lut dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ReadAddress1 (ReadAddress1),
    .ReadBus1     (ReadBus1),
    .WE           (WE),
    .WriteAddress (WriteAddress),
    .WriteBus     (WriteBus),
    .busy         (busy),
    .done         (done)
  );

  // Scratch memory read port: data for an address appears one cycle after it is presented.
  always @(posedge clk) ReadBus1 <= mem[ReadAddress1[7:0]];

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [127:0] uniformWord(input int i);
    logic [127:0] w;
    w = '0;
    for (int j = 0; j < 16; j++) w[8*j +: 8] = 8'(16*i + j);
    return w;
  endfunction

  // kind 0: uniform, 1: 1000 pixels in bin 10, 2: 100 pixels each in bins 0 and 255.
  task automatic loadCdf(input int kind);
    logic [31:0] c, m;
    for (int v = 0; v < 256; v++) begin
      if (kind == 0)      c = 32'(v + 1);
      else if (kind == 1) c = (v < 10) ? 32'd0 : 32'd1000;
      else                c = (v == 255) ? 32'd200 : 32'd100;
      mem[64 + v/4][32*(v%4) +: 32] = c;
    end
    if (kind == 0)      m = 32'd1;
    else if (kind == 1) m = 32'd1000;
    else                m = 32'd100;
    mem[128] = {96'd0, m};
    for (int i = 200; i < 216; i++) mem[i] = GARBAGE;
  endtask

  task automatic clearStats();
    runLen = 0; doneCnt = 0; busyAtDone = 0; weCnt = 0; orderErr = 0;
  endtask

  task automatic applyStimulus(input int kind);
    loadCdf(kind);
    clearStats();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Samples outputs on falling edges for n cycles; captured writes land in mem.
  task automatic watch(input int n);
    for (int c = 0; c < n; c++) begin
      if (busy || done) runLen++;
      if (done) begin
        doneCnt++;
        if (busy) busyAtDone++;
      end
      if (WE) begin
        if (WriteAddress != 16'(200 + weCnt)) orderErr++;
        mem[WriteAddress[7:0]] = WriteBus;
        weCnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic checkTiming(input string tag);
    checkOutput({tag, "_runLen"}, 128'(runLen), 128'd2197);
    checkOutput({tag, "_doneCnt"}, 128'(doneCnt), 128'd1);
    checkOutput({tag, "_busyAtDone"}, 128'(busyAtDone), 128'd0);
    checkOutput({tag, "_weCnt"}, 128'(weCnt), 128'd16);
    checkOutput({tag, "_weOrder"}, 128'(orderErr), 128'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = GARBAGE;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_WE", 128'(WE), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_done", 128'(done), 128'd0);
    checkOutput("rst_ReadAddress1", 128'(ReadAddress1), 128'd0);
    checkOutput("rst_WriteAddress", 128'(WriteAddress), 128'd0);
    checkOutput("rst_WriteBus", WriteBus, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] uniform CDF with a second start 50 cycles in");
    applyStimulus(0);
    watch(50);
    start = 1'b1;
    watch(1);
    start = 1'b0;
    watch(2400);
    checkTiming("uniform");
    checkOutput("uniform_w200", mem[200], 128'h0F0E0D0C0B0A09080706050403020100);
    checkOutput("uniform_w207", mem[207], 128'h7F7E7D7C7B7A79787776757473727170);
    checkOutput("uniform_w215", mem[215], 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);

    $display("[TB] single bin, den = 0");
    applyStimulus(1);
    watch(2400);
    checkTiming("single");
    checkOutput("single_w200", mem[200], 128'hFFFFFFFFFFFF00000000000000000000);
    checkOutput("single_w201", mem[201], {128{1'b1}});
    checkOutput("single_w215", mem[215], {128{1'b1}});

    $display("[TB] two bins, den = 100");
    applyStimulus(2);
    watch(2400);
    checkTiming("twobin");
    checkOutput("twobin_w200", mem[200], 128'd0);
    checkOutput("twobin_w214", mem[214], 128'd0);
    checkOutput("twobin_w215", mem[215], 128'hFF000000000000000000000000000000);

    $display("[TB] reset 300 cycles into a run, then restart");
    applyStimulus(0);
    watch(300);
    reset = 1'b1;
    #1;
    checkOutput("abort_WE", 128'(WE), 128'd0);
    checkOutput("abort_busy", 128'(busy), 128'd0);
    checkOutput("abort_done", 128'(done), 128'd0);
    // Words 200 and 201 are written by cycle 277; word 202 would only come at cycle 414.
    checkOutput("abort_w201_kept", mem[201], uniformWord(1));
    checkOutput("abort_w202_untouched", mem[202], GARBAGE);
    @(negedge clk);
    reset = 1'b0;
    clearStats();
    watch(100);
    checkOutput("abort_noWrites", 128'(weCnt), 128'd0);
    checkOutput("abort_idle", 128'(runLen), 128'd0);
    applyStimulus(0);
    watch(2400);
    checkTiming("restart");
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("restart_w%0d", 200 + i), mem[200 + i], uniformWord(i));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
